// File: rtl/cic_dec_scaler_pkg.sv
`default_nettype none
// ============================================================================
// cic_dec_scaler_pkg : gain-engine state encoding and bit-gain sizing shared
//                      by the CIC decimator/interpolator scalers
// Revision: 1.0
// ============================================================================
package cic_dec_scaler_pkg;

  typedef enum logic [1:0] {
    GAIN_LOAD = 2'd0,
    GAIN_MULT = 2'd1,
    GAIN_ENC  = 2'd2,
    GAIN_IDLE = 2'd3
  } gain_state_e;

  // Worst-case bit gain N*log2(Rmax); also the extra input width over BW.
  function automatic int calc_maxgain(input int n, input int log2_maxrate);
    return n * log2_maxrate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_bitgain_calc.sv
`default_nettype none
// ============================================================================
// cic_bitgain_calc : iterative engine computing shift = ceil(N*log2(rate+1))
//                    as clog2((rate+1)^N), with abort/restart on rate change
// Revision: 1.0
// ============================================================================
module cic_bitgain_calc
  import cic_dec_scaler_pkg::*;
#(
  parameter int N            = 4,
  parameter int LOG2_MAXRATE = 7,
  localparam int MAXGAIN     = calc_maxgain(N, LOG2_MAXRATE),
  localparam int SW          = $clog2(MAXGAIN + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LOG2_MAXRATE-1:0] rate,
  output logic [SW-1:0]           shift,
  output logic                    ready
);

  localparam int PW = MAXGAIN + 1;
  localparam int RW = LOG2_MAXRATE + 1;
  localparam int CW = $clog2(N);

  localparam logic [SW-1:0] SHIFT_RESET = SW'(MAXGAIN);
  localparam logic [CW-1:0] CNT_LOAD    = CW'(N - 2);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [RW-1:0] RATE_ONE    = RW'(1);
  localparam logic [PW-1:0] P_ONE       = PW'(1);

  gain_state_e             state_q, state_d;
  logic [LOG2_MAXRATE-1:0] cur_rate_q, cur_rate_d;
  logic [PW-1:0]           p_q, p_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           shift_q, shift_d;
  logic                    ready_q, ready_d;

  logic [RW-1:0] rate_r;
  logic [RW-1:0] cur_r;
  logic [PW-1:0] p_m1;
  logic [SW-1:0] enc;
  logic          load;

  // clog2(p) = msb_index(p-1)+1, which naturally yields 0 for p==1.
  always_comb begin
    rate_r = {1'b0, rate} + RATE_ONE;
    cur_r  = {1'b0, cur_rate_q} + RATE_ONE;
    p_m1   = p_q - P_ONE;
    enc    = '0;
    for (int i = 0; i < PW; i++) begin
      if (p_m1[i]) enc = SW'(i + 1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_rate_d = cur_rate_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ready_d    = ready_q;
    load       = 1'b0;
    case (state_q)
      GAIN_LOAD: load = 1'b1;
      GAIN_MULT: begin
        if (rate != cur_rate_q) begin
          load = 1'b1;
        end else begin
          p_d = PW'({{RW{1'b0}}, p_q} * {{PW{1'b0}}, cur_r});
          if (cnt_q == '0) state_d = GAIN_ENC;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
      end
      GAIN_ENC: begin
        if (rate != cur_rate_q) begin
          load = 1'b1;
        end else begin
          shift_d = enc;
          ready_d = 1'b1;
          state_d = GAIN_IDLE;
        end
      end
      GAIN_IDLE: begin
        if (rate != cur_rate_q) load = 1'b1;
      end
      default: load = 1'b1;
    endcase
    // A restart never touches shift: the datapath keeps the last valid gain.
    if (load) begin
      cur_rate_d = rate;
      p_d        = {{(PW - RW){1'b0}}, rate_r};
      cnt_d      = CNT_LOAD;
      ready_d    = 1'b0;
      state_d    = GAIN_MULT;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= GAIN_LOAD;
      cur_rate_q <= '0;
      p_q        <= P_ONE;
      cnt_q      <= '0;
      shift_q    <= SHIFT_RESET;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_rate_q <= cur_rate_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ready_q    <= ready_d;
    end
  end

  assign shift = shift_q;
  assign ready = ready_q;

endmodule
`default_nettype wire

// File: rtl/cic_dec_scaler.sv
`default_nettype none
// ============================================================================
// cic_dec_scaler : scales full-precision CIC output to BW bits by the run-time
//                  bit gain, with round-half-up and saturation (2-stage pipe)
// Revision: 1.0
// ============================================================================
module cic_dec_scaler
  import cic_dec_scaler_pkg::*;
#(
  parameter int BW           = 16,
  parameter int N            = 4,
  parameter int LOG2_MAXRATE = 7,
  localparam int MAXGAIN     = calc_maxgain(N, LOG2_MAXRATE)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LOG2_MAXRATE-1:0] rate,
  input  logic                    strobe_in,
  input  logic [BW+MAXGAIN-1:0]   signal_in,
  output logic                    strobe_out,
  output logic [BW-1:0]           signal_out,
  output logic                    ready
);

  localparam int IW  = BW + MAXGAIN;
  localparam int XW  = IW + 1;
  localparam int S1W = BW + 1;
  localparam int SW  = $clog2(MAXGAIN + 1);

  localparam logic [XW-1:0] X_ONE     = XW'(1);
  localparam logic [SW-1:0] SHIFT_ONE = SW'(1);
  localparam logic [BW-1:0] SAT_POS   = {1'b0, {(BW - 1){1'b1}}};
  localparam logic [BW-1:0] SAT_NEG   = {1'b1, {(BW - 1){1'b0}}};

  logic [SW-1:0] shift;

  cic_bitgain_calc #(
    .N            (N),
    .LOG2_MAXRATE (LOG2_MAXRATE)
  ) u_gain (
    .clock (clock),
    .reset (reset),
    .rate  (rate),
    .shift (shift),
    .ready (ready)
  );

  logic [S1W-1:0] s1_q, s1_d;
  logic           s1_valid_q, s1_valid_d;
  logic [BW-1:0]  out_q, out_d;
  logic           strobe_out_q, strobe_out_d;

  logic signed [XW-1:0] x_ext;
  logic        [XW-1:0] rnd;
  logic signed [XW-1:0] x_sum;
  logic        [BW-1:0] sat;

  // Guard bit keeps the rounding add from wrapping at the positive extreme.
  always_comb begin
    x_ext = {signal_in[IW-1], signal_in};
    rnd   = '0;
    if (shift != '0) rnd = X_ONE << (shift - SHIFT_ONE);
    x_sum = x_ext + rnd;
    s1_d       = strobe_in ? S1W'(x_sum >>> shift) : s1_q;
    s1_valid_d = strobe_in;
  end

  always_comb begin
    if (s1_q[BW] != s1_q[BW-1]) sat = s1_q[BW] ? SAT_NEG : SAT_POS;
    else                        sat = s1_q[BW-1:0];
    out_d        = s1_valid_q ? sat : out_q;
    strobe_out_d = s1_valid_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q         <= '0;
      s1_valid_q   <= 1'b0;
      out_q        <= '0;
      strobe_out_q <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s1_valid_q   <= s1_valid_d;
      out_q        <= out_d;
      strobe_out_q <= strobe_out_d;
    end
  end

  assign signal_out = out_q;
  assign strobe_out = strobe_out_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_dec_scaler.sv
`default_nettype none
// ============================================================================
// tb_cic_dec_scaler : vector table, gain sweep and timing corner sequences,
//                     with a scoreboard queue checking every output strobe
// Revision: 1.0
// ============================================================================
module tb_cic_dec_scaler;

  localparam int BW = 16;
  localparam int N  = 4;
  localparam int L  = 7;
  localparam int IW = 44;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [L-1:0]  rate = '0;
  logic          strobe_in = 1'b0;
  logic [IW-1:0] signal_in = '0;
  logic          strobe_out;
  logic [BW-1:0] signal_out;
  logic          ready;

  cic_dec_scaler #(.BW(BW), .N(N), .LOG2_MAXRATE(L)) dut (
    .clock      (clock),
    .reset      (reset),
    .rate       (rate),
    .strobe_in  (strobe_in),
    .signal_in  (signal_in),
    .strobe_out (strobe_out),
    .signal_out (signal_out),
    .ready      (ready)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [BW-1:0] val; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clock) begin
    if (!reset && strobe_out) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe cyc=%0d signal_out=%h required=no strobe", cyc, signal_out);
      end else begin
        mon_e = sb.pop_front();
        if (signal_out !== mon_e.val || cyc != mon_e.due) begin
          failures++;
          $display("FAIL sample actual=%h@%0d required=%h@%0d", signal_out, cyc, mon_e.val, mon_e.due);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      tick(1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
  endtask

  task automatic do_reset(input logic [L-1:0] r);
    reset     = 1'b1;
    strobe_in = 1'b0;
    rate      = r;
    sb.delete();
    tick(2);
    reset = 1'b0;
  endtask

  // Smallest s with 2^s >= R^N.
  function automatic int exp_shift(input int r);
    longint p = 1;
    int s = 0;
    for (int i = 0; i < N; i++) p = p * r;
    while ((longint'(1) << s) < p) s++;
    return s;
  endfunction

  function automatic logic [BW-1:0] exp_out(input longint x, input int s);
    longint y;
    y = (s > 0) ? ((x + (longint'(1) << (s - 1))) >>> s) : x;
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
    return y[BW-1:0];
  endfunction

  typedef struct { logic [L-1:0] rate; logic [IW-1:0] sig; logic [BW-1:0] exp; } vec_t;
  typedef struct { logic [L-1:0] rate; logic [4:0] shift; } svec_t;
  vec_t  vecs[12];
  svec_t svecs[8];

  initial begin
    int c0;
    int s;
    longint x;
    logic signed [23:0] r24;

    vecs[0]  = '{7'd3,   44'h00000123480, 16'h1235};
    vecs[1]  = '{7'd3,   44'h00000000080, 16'h0001};
    vecs[2]  = '{7'd3,   44'hFFFFFFFFF80, 16'h0000};
    vecs[3]  = '{7'd3,   44'hFFFFFFFFF7F, 16'hFFFF};
    vecs[4]  = '{7'd0,   44'h00000001234, 16'h1234};
    vecs[5]  = '{7'd0,   44'hFFFFFFFFFFB, 16'hFFFB};
    vecs[6]  = '{7'd0,   44'h00000008000, 16'h7FFF};
    vecs[7]  = '{7'd0,   44'hFFFFFFF7FFF, 16'h8000};
    vecs[8]  = '{7'd4,   44'h00000100000, 16'h0400};
    vecs[9]  = '{7'd127, 44'h7FFFFFFFFFF, 16'h7FFF};
    vecs[10] = '{7'd127, 44'h80000000000, 16'h8000};
    vecs[11] = '{7'd127, 44'h00018000000, 16'h0002};

    svecs[0] = '{7'd0,   5'd0};
    svecs[1] = '{7'd4,   5'd10};
    svecs[2] = '{7'd5,   5'd11};
    svecs[3] = '{7'd6,   5'd12};
    svecs[4] = '{7'd63,  5'd24};
    svecs[5] = '{7'd106, 5'd27};
    svecs[6] = '{7'd107, 5'd28};
    svecs[7] = '{7'd127, 5'd28};

    // Reset state and first gain computation at rate=3.
    rate = 7'd3;
    tick(2);
    check("rst_signal_out", signal_out, 16'h0);
    check("rst_strobe_out", strobe_out, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_shift", dut.u_gain.shift_q, 5'd28);
    reset = 1'b0;
    tick(1);
    check("ready_edge1", ready, 1'b0);
    tick(3);
    check("ready_edge4", ready, 1'b0);
    tick(1);
    check("ready_edge5", ready, 1'b1);
    check("shift_rate3", dut.u_gain.shift_q, 5'd8);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rate != rate) begin
        rate = vecs[i].rate;
        tick(5);
        check("vec_ready", ready, 1'b1);
      end
      signal_in = vecs[i].sig;
      strobe_in = 1'b1;
      sb.push_back('{vecs[i].exp, cyc + 2});
      tick(1);
      strobe_in = 1'b0;
      tick(1);
    end
    drain();

    for (int i = 0; i < 8; i++) begin
      rate = svecs[i].rate;
      tick(5);
      check("spec_ready", ready, 1'b1);
      check("spec_shift", dut.u_gain.shift_q, svecs[i].shift);
    end

    for (int r = 0; r < 128; r++) begin
      rate = 7'(r);
      tick(4);
      check("sweep_ready_low", ready, 1'b0);
      tick(1);
      check("sweep_ready", ready, 1'b1);
      check("sweep_shift", dut.u_gain.shift_q, 64'(exp_shift(r + 1)));
    end

    // Abort: change 3->4 one cycle after LOAD.
    do_reset(7'd3);
    tick(1);
    check("abort_ready0", ready, 1'b0);
    rate = 7'd4;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("abort_ready", ready, 1'b0);
    end
    check("abort_shift_old", dut.u_gain.shift_q, 5'd28);
    tick(1);
    check("abort_ready_final", ready, 1'b1);
    check("abort_shift", dut.u_gain.shift_q, 5'd10);

    // Continuous strobes across a 3 -> 127 rate change.
    do_reset(7'd3);
    tick(5);
    check("stream_ready", ready, 1'b1);
    c0 = 32'h3fffffff;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        rate = 7'd127;
        c0 = cyc;
      end
      s = (cyc <= c0 + 4) ? 8 : 28;
      r24 = 24'($urandom);
      x = r24;
      if (s == 28) x = x <<< 19;
      signal_in = x[IW-1:0];
      strobe_in = 1'b1;
      sb.push_back('{exp_out(x, s), cyc + 2});
      tick(1);
    end
    strobe_in = 1'b0;
    drain();

    // Reset during MULT with samples in flight.
    do_reset(7'd3);
    tick(5);
    rate = 7'd127;
    signal_in = 44'h00000123480;
    strobe_in = 1'b1;
    tick(2);
    reset = 1'b1;
    strobe_in = 1'b0;
    sb.delete();
    #1;
    check("midrst_signal_out", signal_out, 16'h0);
    check("midrst_strobe_out", strobe_out, 1'b0);
    check("midrst_ready", ready, 1'b0);
    check("midrst_shift", dut.u_gain.shift_q, 5'd28);
    rate = 7'd4;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("postrst_strobe", strobe_out, 1'b0);
      check("postrst_ready", ready, 1'b0);
    end
    tick(1);
    check("postrst_ready_final", ready, 1'b1);
    check("postrst_shift", dut.u_gain.shift_q, 5'd10);
    check("postrst_strobe_final", strobe_out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
